// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - host-side write handshake for the UART transmitter
interface uart_tx_if;
    logic [7:0] Data_Tx;
    logic       Wrsig;
    logic       Tx_Ready;

    modport master (
        output Data_Tx,
        output Wrsig,
        input  Tx_Ready
    );

    modport slave (
        input  Data_Tx,
        input  Wrsig,
        output Tx_Ready
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter (start, 8 data LSB first, parity, stop)
// with a one-entry holding buffer so the next byte can queue behind the current frame.
module uart_tx #(
    parameter logic PARITY_MODE  = 1'b0,
    parameter int   CLKS_PER_BIT = 16
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave bus,
    output logic     Signal_Tx,
    output logic     Busy,
    output logic     Tx_Done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [2:0] r_state;
    logic [7:0] r_clk_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic [7:0] r_hold;
    logic       r_full;
    logic       r_parity;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_bit_end;
    logic       w_load;

    assign w_accept  = bus.Wrsig & ~r_full;
    assign w_bit_end = (r_clk_cnt == LAST_CNT);
    // Load from IDLE, or straight out of the last stop cycle so frames run back to back.
    assign w_load    = r_full & ((r_state == S_IDLE) |
                                 ((r_state == S_STOP) & w_bit_end));

    assign bus.Tx_Ready = ~r_full;
    assign Signal_Tx    = r_tx;
    assign Busy         = r_busy;
    assign Tx_Done      = r_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= 8'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_hold    <= 8'd0;
            r_full    <= 1'b0;
            r_parity  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= bus.Data_Tx;
                r_full <= 1'b1;
            end else if (w_load) begin
                r_full <= 1'b0;
            end

            if (w_load) begin
                r_shift   <= r_hold;
                r_parity  <= PARITY_MODE ^ (^r_hold);
                r_state   <= S_START;
                r_clk_cnt <= 8'd0;
                r_bit_idx <= 3'd0;
            end else if (r_state != S_IDLE) begin
                if (!w_bit_end) begin
                    r_clk_cnt <= r_clk_cnt + 8'd1;
                end else begin
                    r_clk_cnt <= 8'd0;
                    case (r_state)
                        S_START:  r_state <= S_DATA;
                        S_DATA: begin
                            if (r_bit_idx == 3'd7) begin
                                r_bit_idx <= 3'd0;
                                r_state   <= S_PARITY;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                        S_PARITY: r_state <= S_STOP;
                        default:  r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // Line, Busy and Tx_Done are registered from the state, so all three trail it by one cycle together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_shift[r_bit_idx];
                S_PARITY: r_tx <= r_parity;
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_STOP) & w_bit_end;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter. It is the transmit counterpart of the team's 16-clock-per-bit UART receiver, with the same frame format.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). Each bit lasts CLKS_PER_BIT CLK cycles.
- Accepts a byte through a write-strobe/ready handshake and holds it in a one-entry holding buffer, so the next byte can be queued while the current frame shifts out.
- Sits between the host/control logic and the serial line pin.

Parameters:
- PARITY_MODE, 1'b0, parity seed: parity bit = PARITY_MODE ^ (^data). 0 gives even parity, 1 gives odd parity. Must match the receiver's setting.
- CLKS_PER_BIT, 16, CLK cycles per serial bit. Legal range 2..255.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- Data_Tx  in  8  byte to send; sampled only when accepted
- Wrsig  in  1  write strobe; accepted on a rising CLK edge when Wrsig=1 and Tx_Ready=1
- Tx_Ready  out  1  holding buffer empty; a write may be accepted
- Signal_Tx  out  1  serial line; idle high; registered output
- Busy  out  1  a frame is being shifted out
- Tx_Done  out  1  one-cycle pulse in the last cycle of each stop bit

Behaviour:
- Reset (RST=0, asynchronous): Signal_Tx=1, Tx_Ready=1, Busy=0, Tx_Done=0. State=IDLE, counters=0, holding buffer empty.
- Reset asserted mid-frame: the line returns high immediately and the frame is abandoned. No Tx_Done pulse is issued.
- Holding buffer:
  - An accepted write stores Data_Tx and sets buffer-full, so Tx_Ready=0 from the next cycle.
  - Wrsig while Tx_Ready=0 is ignored. The buffered byte is not overwritten.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> (IDLE, or START if the buffer is full).
  - IDLE: Signal_Tx=1, Busy=0. When the buffer is full, move it into the shift register on the next edge: buffer empties (Tx_Ready=1), parity is computed, state=START.
  - START: Signal_Tx=0 for CLKS_PER_BIT cycles.
  - DATA: bit index 0..7, Signal_Tx=shift[index], CLKS_PER_BIT cycles per bit.
  - PARITY: Signal_Tx=PARITY_MODE ^ (^byte), CLKS_PER_BIT cycles.
  - STOP: Signal_Tx=1, CLKS_PER_BIT cycles. Tx_Done=1 in the final cycle.
- After STOP: if the buffer is full, load it and enter START on the next edge with no idle gap. Otherwise go to IDLE.
- Latency: a write accepted at edge N into an idle block gives buffer load at edge N+1 and Signal_Tx=0 from edge N+2.
- Frame length: 11*CLKS_PER_BIT cycles (176 at the default).
- Busy=1 from the first START cycle through the last STOP cycle.
- Bit counter: range 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary. Bit index: range 0..7. Neither counter ever exceeds its range.
- Simultaneous events:
  - A write in the same cycle the buffer is being unloaded into the shift register is not accepted, because Tx_Ready is still 0 in that cycle. The accept happens on the next cycle.
  - A write in the final STOP cycle, while the buffer is empty, is accepted. That byte then follows after one load cycle.
- Signal_Tx is driven directly from a flop: no combinational glitches on the line.

Test Plan:
- Write 0xA5, PARITY_MODE=0 -> Signal_Tx low 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, parity 0, stop 1. Tx_Done pulses exactly 176 cycles after the first start cycle begins. Busy=1 throughout the frame.
- Write 0x01 with PARITY_MODE=0 -> parity bit 1. Same byte with PARITY_MODE=1 -> parity bit 0.
- Write 0x55 then immediately 0xAA (second accepted once Tx_Ready returns to 1) -> two frames, 352 line cycles, no high gap between the 0x55 stop bit and the 0xAA start bit. Two Tx_Done pulses.
- With the buffer full, pulse Wrsig with 0xFF -> ignored. The buffered byte is sent unchanged and Tx_Ready stays 0 until it is unloaded.
- Drop RST during DATA bit 3 -> Signal_Tx=1, Tx_Ready=1, Busy=0 asynchronously. After release, a new write of 0x3C transmits correctly.
- Loopback Signal_Tx into the receiver (same PARITY_MODE), sending 0x00, 0xFF, 0x5A, 0xC3 -> receiver Data_Rx matches each byte, DataError_Flag=0, FrameError_Flag=0.
